// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational ALU between NREQ requesters; optional ALU_SCHED_DIVZERO_EN short-circuits divide-by-zero.
// Latency: response strobe L+1 cycles after the grant cycle (L = 1, MUL_LAT or DIV_LAT); back-to-back period L+1.
// Backpressure: one op in flight, req_ready held low while executing; responses are a strobe with no backpressure.
module alu_sched #(
  parameter int N       = 32,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*N-1:0]        req_a,
  input  logic [NREQ*N-1:0]        req_b,
  input  logic [NREQ*4-1:0]        req_op,
  output logic [NREQ-1:0]          req_ready,
  output logic [N-1:0]             alu_a,
  output logic [N-1:0]             alu_b,
  output logic [3:0]               alu_ctrl,
  input  logic [N-1:0]             alu_result,
  input  logic                     alu_cout,
  input  logic                     alu_zero,
  input  logic                     alu_neg,
  input  logic                     alu_overflow,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [N-1:0]             rsp_result,
  output logic [3:0]               rsp_flags,
  output logic                     busy
);

  localparam int IDW  = $clog2(NREQ);
  localparam int LMAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(LMAX + 1);

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Operation held on the ALU inputs for the whole execute window.
  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ctrl;
  } op_t;

  state_t          state_q;
  state_t          state_d;
  logic [IDW-1:0]  ptr_q;
  logic [CW-1:0]   cnt_q;
  op_t             op_q;
  op_t             op_sel;
  logic            grant_any;
  logic [IDW-1:0]  grant_id;
  logic            accept;
  logic [CW-1:0]   lat_sel;
  logic            last_exec;
  logic [IDW-1:0]  ptr_next;
`ifdef ALU_SCHED_DIVZERO_EN
  logic            dz_sel;
  logic            dz_q;
`endif

  // Round-robin search: first valid requester at or after ptr, wrapping; only offered outside EXEC and out of reset.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    if (state_q != EXEC && !rst) begin
      // Walk offsets from farthest to nearest so the nearest valid requester wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (req_valid[idx]) begin
          grant_any = 1'b1;
          grant_id  = IDW'(idx);
        end
      end
    end
  end

  assign req_ready = grant_any ? (NREQ'(1) << grant_id) : '0;
  assign accept    = |(req_valid & req_ready);
  assign ptr_next  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  // Payload mux and execute-length decode for the granted requester.
  always_comb begin
    op_sel.a    = req_a[int'(grant_id)*N +: N];
    op_sel.b    = req_b[int'(grant_id)*N +: N];
    op_sel.ctrl = req_op[int'(grant_id)*4 +: 4];
    case (op_sel.ctrl)
      OP_MUL:  lat_sel = CW'(MUL_LAT);
      OP_DIV:  lat_sel = CW'(DIV_LAT);
      default: lat_sel = CW'(1);
    endcase
`ifdef ALU_SCHED_DIVZERO_EN
    // A zero divisor never reaches the divider result, so there is nothing to wait for.
    dz_sel = (op_sel.ctrl == OP_DIV) && (op_sel.b == '0);
    if (dz_sel) lat_sel = CW'(1);
`endif
  end

  assign last_exec = (state_q == EXEC) && (cnt_q == CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept enters EXEC from IDLE or RESP; the L-th execute cycle moves to RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (last_exec) state_d = RESP;
      RESP:    state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy      = (state_q == EXEC);
    rsp_valid = (state_q == RESP);
  end

  // Datapath: latch the granted op on accept, count down the execute window, capture the ALU at its end.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
`ifdef ALU_SCHED_DIVZERO_EN
      dz_q       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q   <= op_sel;
        rsp_id <= grant_id;
        ptr_q  <= ptr_next;
        cnt_q  <= lat_sel;
`ifdef ALU_SCHED_DIVZERO_EN
        dz_q   <= dz_sel;
`endif
      end else if (state_q == EXEC && !last_exec) begin
        cnt_q <= cnt_q - CW'(1);
      end

      if (last_exec) begin
`ifdef ALU_SCHED_DIVZERO_EN
        if (dz_q) begin
          rsp_result <= '0;
          rsp_flags  <= 4'b1000;
        end else begin
          rsp_result <= alu_result;
          rsp_flags  <= {alu_overflow, alu_neg, alu_zero, alu_cout};
        end
`else
        rsp_result <= alu_result;
        rsp_flags  <= {alu_overflow, alu_neg, alu_zero, alu_cout};
`endif
      end
    end
  end

  assign alu_a    = op_q.a;
  assign alu_b    = op_q.b;
  assign alu_ctrl = op_q.ctrl;

  // Grant is one-hot and never offered while an op is executing.
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_no_grant_busy: assert property (@(posedge clk) disable iff (rst) !(busy && (|req_ready)));

endmodule
